iram_dumper: RTL and testbench

//  SPI-slave transmit path: streams IRAM contents back to the host on MISO, the

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 35 +++
 rtl/iram_dumper.sv | 155 +++++++++++++++
 tb/tb_iram_dumper.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI-side types and constants for the IRAM download/readback paths.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        SHIFT
    } dump_state_t;

    localparam int SYNC_STAGES    = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/spi_sync.sv
// Brings one asynchronous SPI pin into the system clock domain.
// Provides the synchronized level and single-cycle rise/fall pulses.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // The edge-detect stage resets to the same value as the synchronizer.
    // This keeps reset release from being seen as a pin edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/iram_dumper.sv
// SPI-slave transmit path that streams IRAM words to the host on MISO.
// Bytes go out least-significant first, with bits of each byte sent MSB first.
module iram_dumper
    import spi_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dc_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    output logic              spi_miso_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [XLEN-1:0]   rd_data_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    dump_state_t       state, state_next;
    logic [XLEN-1:0]   word_buf, next_buf;
    logic [2:0]        bit_idx;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] addr, next_addr;
    logic              pref_req, pref_cap;
    logic              start, abort;
    logic              sclk_level, sclk_rise, sclk_fall;
    logic              cs_level, cs_rise, cs_fall;
    logic              dc_level, dc_rise, dc_fall;
    logic              unused_sync;

    spi_sync #(.RESET_VAL(1'b0)) sclk_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .din   (spi_sclk_i),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync #(.RESET_VAL(1'b1)) cs_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .din   (spi_cs_n_i),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync #(.RESET_VAL(1'b0)) dc_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .din   (dc_i),
        .level (dc_level),
        .rise  (dc_rise),
        .fall  (dc_fall)
    );

    // The transmit path only needs SCLK falls, CS edges and the DC level.
    assign unused_sync = &{1'b0, sclk_level, sclk_rise, cs_level, dc_rise, dc_fall};

    assign start     = (state == IDLE) && cs_fall && !dc_level;
    assign abort     = (state != IDLE) && cs_rise;
    assign next_addr = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   state_next = SHIFT;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // On the fall that starts byte 3, the next word is requested into next_buf.
    // The word boundary then swaps buffers with no SCLK stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_buf   <= '0;
            next_buf   <= '0;
            bit_idx    <= 3'd7;
            byte_idx   <= 2'd0;
            addr       <= '0;
            pref_req   <= 1'b0;
            pref_cap   <= 1'b0;
            spi_miso_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            pref_req <= 1'b0;
            pref_cap <= pref_req;
            done_o   <= abort;
            if (pref_cap) next_buf <= rd_data_i;
            if (abort) begin
                spi_miso_o <= 1'b0;
                addr       <= '0;
                bit_idx    <= 3'd7;
                byte_idx   <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso_o <= 1'b0;
                        if (start) addr <= '0;
                    end
                    LOAD: begin
                        word_buf   <= rd_data_i;
                        byte_idx   <= 2'd0;
                        bit_idx    <= 3'd7;
                        spi_miso_o <= rd_data_i[7];
                        addr       <= next_addr;
                    end
                    SHIFT: begin
                        if (sclk_fall) begin
                            if (bit_idx != 3'd0) begin
                                bit_idx    <= bit_idx - 3'd1;
                                spi_miso_o <= word_buf[{byte_idx, bit_idx - 3'd1}];
                            end else if (byte_idx != LAST_BYTE) begin
                                byte_idx   <= byte_idx + 2'd1;
                                bit_idx    <= 3'd7;
                                spi_miso_o <= word_buf[{byte_idx + 2'd1, 3'd7}];
                                if (byte_idx == LAST_BYTE - 2'd1) pref_req <= 1'b1;
                            end else begin
                                word_buf   <= next_buf;
                                byte_idx   <= 2'd0;
                                bit_idx    <= 3'd7;
                                spi_miso_o <= next_buf[7];
                                addr       <= next_addr;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_en_o   = (state == FETCH) || pref_req;
    assign rd_addr_o = addr;
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_iram_dumper.sv
// Bench for iram_dumper: a 2048-deep and a 4-deep instance share one SPI bus.
// The streamed bits are compared with a byte-stream model of the IRAM contents.
module tb_iram_dumper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dc = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;

    logic        miso_a, rd_en_a, busy_a, done_a;
    logic [10:0] rd_addr_a;
    logic [31:0] rd_data_a;
    logic        miso_b, rd_en_b, busy_b, done_b;
    logic [1:0]  rd_addr_b;
    logic [31:0] rd_data_b;

    logic [31:0] mem_a [2048];
    logic [31:0] mem_b [4];

    int compared, mismatched;
    int done_cnt_a, done_cnt_b, idle_bad;
    int addr_q_a[$], addr_q_b[$];
    bit bits_a[$], bits_b[$];
    int done_base_a, done_base_b, addr_base_a, addr_base_b;

    always #5 clk = ~clk;

    iram_dumper #(.XLEN(32), .ADDR_W(11), .DEPTH(2048)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .dc_i(dc), .spi_sclk_i(sclk), .spi_cs_n_i(cs_n),
        .spi_miso_o(miso_a), .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a),
        .rd_data_i(rd_data_a), .busy_o(busy_a), .done_o(done_a)
    );

    iram_dumper #(.XLEN(32), .ADDR_W(2), .DEPTH(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .dc_i(dc), .spi_sclk_i(sclk), .spi_cs_n_i(cs_n),
        .spi_miso_o(miso_b), .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b),
        .rd_data_i(rd_data_b), .busy_o(busy_b), .done_o(done_b)
    );

    // Synchronous-read IRAMs that hold their output until the next read.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
    end

    always @(negedge clk) begin
        if (rd_en_a === 1'b1) addr_q_a.push_back(int'(rd_addr_a));
        if (rd_en_b === 1'b1) addr_q_b.push_back(int'(rd_addr_b));
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
        if ((busy_a === 1'b0 && miso_a !== 1'b0) || (busy_b === 1'b0 && miso_b !== 1'b0))
            idle_bad <= idle_bad + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int s, input int k);
        logic [31:0] word;
        word = (s == 0) ? mem_a[(k / 4) % 2048] : mem_b[(k / 4) % 4];
        return word[8 * (k % 4) +: 8];
    endfunction

    task automatic apply_stimulus(input int nbits, input logic dc_sel, input bit do_close);
        dc = dc_sel;
        repeat (4) @(negedge clk);
        bits_a.delete();
        bits_b.delete();
        done_base_a = done_cnt_a;
        done_base_b = done_cnt_b;
        addr_base_a = addr_q_a.size();
        addr_base_b = addr_q_b.size();
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        check_output("busy_a_in_session", busy_a, !dc_sel);
        check_output("busy_b_in_session", busy_b, !dc_sel);
        for (int i = 0; i < nbits; i++) begin
            bits_a.push_back(miso_a);
            bits_b.push_back(miso_b);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (do_close) begin
            cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic check_session(input int nbits, input logic dc_sel);
        for (int s = 0; s < 2; s++) begin
            int   depth;
            int   rem;
            int   done_now;
            int   exp_addr[$];
            int   got_addr[$];
            bit   got_bits[$];
            logic [7:0] gb;
            logic [7:0] eb;
            depth = (s == 0) ? 2048 : 4;
            if (s == 0) begin
                got_bits = bits_a;
                for (int i = addr_base_a; i < addr_q_a.size(); i++) got_addr.push_back(addr_q_a[i]);
                done_now = done_cnt_a - done_base_a;
            end else begin
                got_bits = bits_b;
                for (int i = addr_base_b; i < addr_q_b.size(); i++) got_addr.push_back(addr_q_b[i]);
                done_now = done_cnt_b - done_base_b;
            end
            for (int k = 0; k < nbits / 8; k++) begin
                gb = 8'h00;
                for (int j = 0; j < 8; j++) gb = {gb[6:0], got_bits[8 * k + j]};
                eb = dc_sel ? 8'h00 : model_byte(s, k);
                check_output($sformatf("dut%0d_byte%0d", s, k), gb, eb);
            end
            rem = nbits % 8;
            if (rem != 0) begin
                gb = 8'h00;
                for (int j = 0; j < rem; j++) gb = {gb[6:0], got_bits[8 * (nbits / 8) + j]};
                eb = dc_sel ? 8'h00 : (model_byte(s, nbits / 8) >> (8 - rem));
                check_output($sformatf("dut%0d_partial", s), gb, eb);
            end
            if (!dc_sel) begin
                exp_addr.push_back(0);
                for (int b = 1; 8 * b <= nbits; b++)
                    if (b % 4 == 3) exp_addr.push_back((b / 4 + 1) % depth);
            end
            check_output($sformatf("dut%0d_rd_count", s), got_addr.size(), exp_addr.size());
            for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
                check_output($sformatf("dut%0d_rd_addr%0d", s, i), got_addr[i], exp_addr[i]);
            check_output($sformatf("dut%0d_done_pulses", s), done_now, dc_sel ? 0 : 1);
            check_output($sformatf("dut%0d_busy_after", s), (s == 0) ? busy_a : busy_b, 1'b0);
            check_output($sformatf("dut%0d_miso_after", s), (s == 0) ? miso_a : miso_b, 1'b0);
        end
        check_output("miso_outside_session", idle_bad, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_miso_a"}, miso_a, 1'b0);
        check_output({tag, "_rd_en_a"}, rd_en_a, 1'b0);
        check_output({tag, "_rd_addr_a"}, rd_addr_a, 0);
        check_output({tag, "_busy_a"}, busy_a, 1'b0);
        check_output({tag, "_done_a"}, done_a, 1'b0);
        check_output({tag, "_miso_b"}, miso_b, 1'b0);
        check_output({tag, "_rd_en_b"}, rd_en_b, 1'b0);
        check_output({tag, "_rd_addr_b"}, rd_addr_b, 0);
        check_output({tag, "_busy_b"}, busy_b, 1'b0);
        check_output({tag, "_done_b"}, done_b, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem_a[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem_b[i] = 32'(i) * 32'h0101_0101;
        mem_a[0] = 32'h4433_2211;
        mem_a[1] = 32'h8877_6655;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        apply_stimulus(64, 1'b0, 1'b1);
        check_session(64, 1'b0);

        apply_stimulus(160, 1'b0, 1'b1);
        check_session(160, 1'b0);

        apply_stimulus(3, 1'b0, 1'b1);
        check_session(3, 1'b0);
        apply_stimulus(8, 1'b0, 1'b1);
        check_session(8, 1'b0);

        apply_stimulus(32, 1'b1, 1'b1);
        check_session(32, 1'b1);

        for (int i = 0; i < 2048; i++) mem_a[i] = $urandom;
        for (int i = 0; i < 4; i++) mem_b[i] = $urandom;
        apply_stimulus(2048, 1'b0, 1'b1);
        check_session(2048, 1'b0);

        // Reset lands inside byte 2; no done pulse may escape and the next dump restarts at word 0.
        apply_stimulus(19, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check_output("midreset_done_a", done_cnt_a - done_base_a, 0);
        check_output("midreset_done_b", done_cnt_b - done_base_b, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        apply_stimulus(8, 1'b0, 1'b1);
        check_session(8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
